// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter: iterative AES InvSubBytes stage.
// Substitutes BYTES_PER_CYCLE bytes of a 128-bit state per cycle through
// inv_s_box lookups, lowest byte indices first, with valid/ready on both sides.
// Optional build macro INV_SUB_BYTES_SELFCHECK_EN adds a forward S-box
// round-trip check and the check_err output.

// Combinational FIPS-197 inverse S-box lookup.
module inv_s_box (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    // Entry 0 occupies the MSBs, so entry a starts at bit 8*(255-a) = {~a,3'b000}.
    assign y = TBL[{~a, 3'b000} +: 8];
endmodule

`ifdef INV_SUB_BYTES_SELFCHECK_EN
// Combinational FIPS-197 forward S-box lookup.
module s_box (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = TBL[{~a, 3'b000} +: 8];
endmodule
`endif

module inv_sub_bytes_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef INV_SUB_BYTES_SELFCHECK_EN
    output logic         check_err,
`endif
    output logic         busy
);
    localparam int NCHUNK = 16 / BYTES_PER_CYCLE;
    localparam int CW     = $clog2(NCHUNK) + 1;
    localparam int CHW    = 8 * BYTES_PER_CYCLE;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PROC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [127:0]   data;
    logic [127:0]   data_nxt;
    logic [6:0]     base;
    logic [CHW-1:0] chunk_in;
    logic [CHW-1:0] chunk_out;
    logic           last_chunk;

    assign in_ready   = (state == IDLE);
    assign busy       = (state == PROC) || (state == DONE);
    assign out        = data;
    assign last_chunk = (cnt == CW'(NCHUNK - 1));

    // Select the current chunk of the state for the S-box bank.
    always_comb begin
        base     = 7'(int'(cnt) * CHW);
        chunk_in = data[base +: CHW];
    end

    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_inv
        inv_s_box u_inv (
            .a (chunk_in[8*j +: 8]),
            .y (chunk_out[8*j +: 8])
        );
    end

    // Next state value: current chunk replaced while in PROC, otherwise unchanged.
    always_comb begin
        data_nxt = data;
        if (state == PROC) begin
            data_nxt[base +: CHW] = chunk_out;
        end
    end

    // Control FSM, chunk counter and state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            data      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data  <= in;
                        cnt   <= '0;
                        state <= PROC;
                    end
                end
                PROC: begin
                    data <= data_nxt;
                    cnt  <= cnt + CW'(1);
                    if (last_chunk) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INV_SUB_BYTES_SELFCHECK_EN
    logic [127:0] orig;
    logic [127:0] fwd;

    // Forward S-boxes look at data_nxt so the final chunk is already folded in
    // on the PROC->DONE edge; in DONE data_nxt equals data.
    for (genvar k = 0; k < 16; k++) begin : g_fwd
        s_box u_fwd (
            .a (data_nxt[8*k +: 8]),
            .y (fwd[8*k +: 8])
        );
    end

    // Capture the input block and flag a failed round trip at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orig      <= '0;
            check_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        orig      <= in;
                        check_err <= 1'b0;
                    end
                end
                PROC: begin
                    if (last_chunk) begin
                        check_err <= (fwd != orig);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        check_err <= 1'b0;
                    end
                end
                default: check_err <= 1'b0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb_inv_sub_bytes_iter: self-checking bench for inv_sub_bytes_iter.
// Five instances (BYTES_PER_CYCLE = 4, 1, 2, 8, 16) share clock and reset.
// Expected values come from an S-box built by GF(2^8) arithmetic and inverted.
module tb_inv_sub_bytes_iter;
    localparam int NDUT = 5;
    localparam int BPCS [NDUT] = '{4, 1, 2, 8, 16};

    logic         clk;
    logic         rst_n;
    logic [127:0] in_s       [NDUT];
    logic         in_valid_s [NDUT];
    logic         in_ready_s [NDUT];
    logic [127:0] out_s      [NDUT];
    logic         out_valid_s[NDUT];
    logic         out_ready_s[NDUT];
    logic         busy_s     [NDUT];
    logic         check_err_s[NDUT];

    int n_checks;
    int n_fail;

    logic [7:0] sbox_ref [256];
    logic [7:0] inv_ref  [256];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        inv_sub_bytes_iter #(.BYTES_PER_CYCLE(BPCS[g])) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in        (in_s[g]),
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_s[g]),
            .out       (out_s[g]),
            .out_valid (out_valid_s[g]),
            .out_ready (out_ready_s[g]),
`ifdef INV_SUB_BYTES_SELFCHECK_EN
            .check_err (check_err_s[g]),
`endif
            .busy      (busy_s[g])
        );
`ifndef INV_SUB_BYTES_SELFCHECK_EN
        assign check_err_s[g] = 1'b0;
`endif
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] w = {x, x};
        return w[15-n -: 8];
    endfunction

    // S(x) = affine(x^-1); the inverse table is the inverse permutation of S.
    task automatic build_tables();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v = 8'h00;
            logic [7:0] b;
            for (int c = 1; c < 256; c++) begin
                if (i != 0 && gmul(8'(i), 8'(c)) == 8'h01) v = 8'(c);
            end
            b = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
            sbox_ref[i] = b;
            inv_ref[b]  = 8'(i);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] x);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_ref[x[8*k +: 8]];
        return r;
    endfunction

    // Drive one block into instance d; lat = edges from accept to out_valid, -1 on timeout.
    task automatic send_block(input int d, input logic [127:0] blk, output int lat);
        @(negedge clk);
        in_s[d]       = blk;
        in_valid_s[d] = 1'b1;
        @(negedge clk);
        in_valid_s[d] = 1'b0;
        lat = 0;
        while (!out_valid_s[d] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid_s[d]) lat = -1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < NDUT; d++) begin
            in_s[d] = '0; in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b1;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (out_s[d] !== 128'h0 || out_valid_s[d] !== 1'b0 || in_ready_s[d] !== 1'b1 ||
                busy_s[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset d=%0d out=%h ov=%b ir=%b busy=%b req out=0 ov=0 ir=1 busy=0",
                         d, out_s[d], out_valid_s[d], in_ready_s[d], busy_s[d]);
            end
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [127:0] vin  [3];
        logic [127:0] vexp [3];
        int lat;
        vin[0] = {16{8'h63}};                      vexp[0] = 128'h0;
        vin[1] = 128'h0;                           vexp[1] = {16{8'h52}};
        vin[2] = {{13{8'h63}}, 8'hED, 8'h7C, 8'h16}; vexp[2] = {{13{8'h00}}, 8'h53, 8'h01, 8'hFF};
        out_ready_s[0] = 1'b1;
        for (int v = 0; v < 3; v++) begin
            send_block(0, vin[v], lat);
            n_checks++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL vec_latency v=%0d got=%0d req=4", v, lat);
            end
            n_checks++;
            if (out_s[0] !== vexp[v] || out_s[0] !== model(vin[v])) begin
                n_fail++;
                $display("FAIL vec_out v=%0d got=%h req=%h", v, out_s[0], vexp[v]);
            end
            @(negedge clk);
            n_checks++;
            if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1 || busy_s[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL vec_idle v=%0d ov=%b ir=%b busy=%b req ov=0 ir=1 busy=0",
                         v, out_valid_s[0], in_ready_s[0], busy_s[0]);
            end
        end
    endtask

    task automatic test_stall();
        logic [127:0] blk = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] exp = model(blk);
        int lat;
        out_ready_s[0] = 1'b0;
        send_block(0, blk, lat);
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL stall_latency got=%0d req=4", lat);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid_s[0] !== 1'b1 || out_s[0] !== exp || in_ready_s[0] !== 1'b0 ||
                busy_s[0] !== 1'b1 || check_err_s[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold i=%0d ov=%b out=%h ir=%b busy=%b ce=%b req ov=1 out=%h ir=0 busy=1 ce=0",
                         i, out_valid_s[0], out_s[0], in_ready_s[0], busy_s[0], check_err_s[0], exp);
            end
            in_s[0]       = ~blk;
            in_valid_s[0] = 1'b1;
        end
        in_valid_s[0]  = 1'b0;
        out_ready_s[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1 || out_s[0] !== exp) begin
            n_fail++;
            $display("FAIL stall_drain ov=%b ir=%b out=%h req ov=0 ir=1 out=%h",
                     out_valid_s[0], in_ready_s[0], out_s[0], exp);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1 || busy_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_idle ov=%b ir=%b busy=%b req ov=0 ir=1 busy=0",
                     out_valid_s[0], in_ready_s[0], busy_s[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] blk = {$urandom, $urandom, $urandom, $urandom};
        int lat;
        out_ready_s[0] = 1'b1;
        @(negedge clk);
        in_s[0] = blk; in_valid_s[0] = 1'b1;
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_s[0] !== 128'h0 || out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset out=%h ov=%b ir=%b req out=0 ov=0 ir=1",
                     out_s[0], out_valid_s[0], in_ready_s[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        blk = {$urandom, $urandom, $urandom, $urandom};
        send_block(0, blk, lat);
        n_checks++;
        if (lat !== 4 || out_s[0] !== model(blk)) begin
            n_fail++;
            $display("FAIL midreset_after lat=%0d out=%h req lat=4 out=%h", lat, out_s[0], model(blk));
        end
        @(negedge clk);
    endtask

    task automatic test_random_sweep();
        int lat;
        int bad;
        for (int d = 0; d < NDUT; d++) begin
            out_ready_s[d] = 1'b1;
            bad = 0;
            for (int n = 0; n < 100; n++) begin
                logic [127:0] blk = {$urandom, $urandom, $urandom, $urandom};
                send_block(d, blk, lat);
                n_checks++;
                if (lat !== 16 / BPCS[d] || out_s[d] !== model(blk) || check_err_s[d] !== 1'b0) begin
                    n_fail++;
                    bad++;
                    if (bad <= 5)
                        $display("FAIL sweep bpc=%0d n=%0d lat=%0d out=%h ce=%b req lat=%0d out=%h ce=0",
                                 BPCS[d], n, lat, out_s[d], check_err_s[d], 16 / BPCS[d], model(blk));
                    if (lat < 0) begin
                        rst_n = 1'b0;
                        #1 rst_n = 1'b1;
                    end
                end
            end
            @(negedge clk);
            n_checks++;
            if (in_ready_s[d] !== 1'b1 || out_valid_s[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_idle bpc=%0d ir=%b ov=%b req ir=1 ov=0",
                         BPCS[d], in_ready_s[d], out_valid_s[d]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        build_tables();
        test_reset();
        test_vectors();
        test_stall();
        test_reset_mid();
        test_random_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
